if_stage_prefetch: RTL and testbench

- Instruction fetch stage. It is the producer side of the instruction/PC interface consumed by the decode stage.
- Keeps the fetch PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid flag.
- Handles freeze (hazard) and branch redirect/flush from execute.

---
 rtl/if_stage_prefetch.sv | 217 +++++++++++++++++++++
 tb/tb_if_stage_prefetch.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_prefetch.sv
// ---------------------------------------------------------------------------
// if_stage_prefetch
//
// Instruction fetch stage. It holds the fetch PC and keeps at most one request
// outstanding to instruction memory. Returned words go into a small prefetch
// FIFO, and the head of that FIFO is presented to decode as
// {valid, instruction, pc}. Decode can hold the head with freeze. Execute can
// redirect fetch with branch_taken, which flushes everything that was buffered.
//
// Optional feature (macro IF_PERF_CNT_EN):
//   stall_cycles : saturating count of cycles with valid=0 (out of reset)
//   flush_count  : saturating count of branch_taken edges
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   freeze              decode cannot accept the head entry this cycle
//   branch_taken        redirect fetch to branch_addr (word-aligned down)
//   branch_addr         redirect target
//   imem_req/imem_addr  registered memory request, held until imem_ack
//   imem_ack/imem_rdata response; completes the outstanding request
//   valid               head entry holds a real instruction
//   instruction         head instruction word, 0 when valid=0
//   pc                  head instruction address + 4, 0 when valid=0
//   stall_cycles        (IF_PERF_CNT_EN only)
//   flush_count         (IF_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module if_stage_prefetch #(
    parameter int                    BIT_NUMBER = 32,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic                  valid,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic [BIT_NUMBER-1:0] pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           flush_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_NUMBER-1:0] PC_STEP   = BIT_NUMBER'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    fetch_state_t            state_q, state_d;
    logic [BIT_NUMBER-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    req_q, req_d;
    logic [BIT_NUMBER-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [BIT_NUMBER-1:0]   fifo_word [FIFO_DEPTH];
    logic [BIT_NUMBER-1:0]   fifo_addr [FIFO_DEPTH];

    logic                    ack_live;
    logic                    do_push;
    logic                    do_pop;
    logic                    can_issue;

    // The low two bits of a branch target are ignored because fetch is
    // always word aligned. This signal keeps those bits formally consumed.
    logic                    branch_addr_unused;
    assign branch_addr_unused = ^branch_addr[1:0];

    // Datapath decisions for the coming edge.
    // An ack only counts while a request is actually outstanding. A branch
    // overrides push and pop, so the FIFO is simply emptied. A new request
    // may be issued only if the FIFO would still have a free slot after this
    // edge's push/pop. That guarantees the returning word always has room.
    always_comb begin
        ack_live   = imem_ack && req_q;
        do_pop     = (count_q != '0) && !freeze && !branch_taken;
        do_push    = (state_q == REQ) && ack_live && !branch_taken;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        if (branch_taken) begin
            count_d    = '0;
            fetch_pc_d = {branch_addr[BIT_NUMBER-1:2], 2'b00};
        end else begin
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (do_push) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
        can_issue = (count_d < DEPTH_CNT);
    end

    // Request FSM, next-state half.
    // REQ keeps the returned word. DROP waits out a request that a branch
    // made stale; the word it returns is thrown away. When any outstanding
    // request completes, the next one goes out back-to-back at fetch_pc_d
    // if there is room. That is what gives one instruction per cycle with a
    // zero-wait memory. IDLE never issues on a branch edge; it picks up the
    // new target on the following cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (!branch_taken && can_issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                end
            end
            REQ, DROP: begin
                if (ack_live) begin
                    if (can_issue) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else if (branch_taken) begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request and FIFO bookkeeping registers.
    // A flush rewinds both pointers, so the FIFO restarts cleanly at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            if (branch_taken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage. The entry address is the held request address, which
    // is exactly the address the returned word belongs to. Storage needs no
    // reset because the count gates everything that is read out.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            fifo_word[wr_ptr_q] <= imem_rdata;
            fifo_addr[wr_ptr_q] <= addr_q;
        end
    end

    // Outputs come only from registers, so memory has no combinational
    // path to decode.
    always_comb begin
        imem_req    = req_q;
        imem_addr   = addr_q;
        valid       = (count_q != '0);
        instruction = '0;
        pc          = '0;
        if (valid) begin
            instruction = fifo_word[rd_ptr_q];
            pc          = fifo_addr[rd_ptr_q] + PC_STEP;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters. Both saturate instead of wrapping, so a
    // long-running count never looks small.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!valid && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_stage_prefetch
//
// Bench for if_stage_prefetch. The memory model returns mem[a] =
// 0xE3A00000 + a/4 after a programmable number of wait cycles, or acks
// randomly. The reference model is the program-order instruction stream:
// consumed instructions must follow it from the last reset or redirect
// target. Expected entries sit in a queue, and a monitor compares the head
// every cycle.
// ---------------------------------------------------------------------------
module tb_if_stage_prefetch;

    localparam int          BW     = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    int mem_wait   = 0;
    bit mem_random = 1'b0;
    bit rand_ack   = 1'b0;
    int wait_cnt   = 0;
    bit live_en    = 1'b0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_addr;

    if_stage_prefetch #(
        .BIT_NUMBER (BW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .instruction  (instruction),
        .pc           (pc)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE3A0_0000 + (a >> 2);
    endfunction

    // Memory model: either a fixed number of wait cycles per request or a
    // random ack. Read data is always the word at the requested address.
    assign imem_ack   = imem_req && (mem_random ? rand_ack : (wait_cnt >= mem_wait));
    assign imem_rdata = mem_word(imem_addr);

    // Memory wait counter, shares the design's reset.
    always @(posedge clk) begin
        if (rst || (imem_req && imem_ack)) begin
            wait_cnt <= 0;
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Random ack decision, refreshed away from the active edge.
    always @(negedge clk) begin
        rand_ack = ($urandom_range(0, 9) < 6);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic b, input logic [31:0] a);
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
    endtask

    task automatic applyReset(input int wait_cycles, input bit random_mem);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        mem_wait   = wait_cycles;
        mem_random = random_mem;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.instr = mem_word(gen_addr);
            e.pc    = gen_addr + 32'd4;
            exp_q.push_back(e);
            gen_addr = gen_addr + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] a);
        exp_q.delete();
        gen_addr = a;
        refill();
    endtask

    // Monitor and scoreboard. Sampled 1 unit after the negedge, when the
    // outputs reflect the last edge and the inputs for the next edge are
    // settled. It checks the head against the expected stream, zeros when
    // empty, empty after flush, and request stability. Then it advances the
    // model for the coming edge.
    initial begin
        bit          first = 1'b1;
        logic        prev_flush = 1'b0;
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic        prev_rst = 1'b1;
        logic [31:0] prev_addr = 32'h0;
        int          idle_run = 0;
        redirect(RST_PC);
        forever begin
            @(negedge clk);
            #1;
            if (!first) begin
                if (prev_flush) begin
                    checkOutput("valid_after_flush", 32'(valid), 32'd0);
                end
                if (valid) begin
                    checkOutput("head_instr", instruction, exp_q[0].instr);
                    checkOutput("head_pc", pc, exp_q[0].pc);
                end else begin
                    checkOutput("instr_zero_when_empty", instruction, 32'd0);
                    checkOutput("pc_zero_when_empty", pc, 32'd0);
                end
                if (prev_req && !prev_ack && !prev_rst) begin
                    checkOutput("req_held", 32'(imem_req), 32'd1);
                    checkOutput("addr_held", imem_addr, prev_addr);
                end
            end
            first = 1'b0;
            if (rst) begin
                redirect(RST_PC);
            end else if (branch_taken) begin
                redirect({branch_addr[31:2], 2'b00});
            end else if (valid && !freeze) begin
                void'(exp_q.pop_front());
                refill();
            end
            if (live_en && !rst) begin
                if (valid && !freeze && !branch_taken) begin
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (idle_run > 60) begin
                    checkOutput("liveness_timeout", 32'(idle_run), 32'd60);
                    idle_run = 0;
                end
            end else begin
                idle_run = 0;
            end
            prev_flush = rst || branch_taken;
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_rst   = rst;
            prev_addr  = imem_addr;
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        bit found;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, RST_PC);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_instruction", instruction, 32'd0);
        checkOutput("rst_pc", pc, 32'd0);

`ifdef IF_PERF_CNT_EN
        $display("[TB] perf counters");
        applyReset(1000, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("stall_cycles_4", stall_cycles, 32'd4);
        applyStimulus(1'b0, 1'b1, 32'h40);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h80);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("flush_count_2", 32'(flush_count), 32'd2);
`endif

        $display("[TB] zero-wait streaming");
        applyReset(0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("valid_rise_2_cycles", 32'(valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("stream_valid", 32'(valid), 32'd1);
            checkOutput("stream_pc", pc, 32'(4 * (k + 1)));
            checkOutput("stream_instr", instruction, 32'hE3A0_0000 + 32'(k));
            @(negedge clk);
        end

        $display("[TB] freeze at pc=8");
        applyReset(0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid && pc == 32'd8) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("freeze_wait_pc8", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("freeze_pc_stable", pc, 32'd8);
            checkOutput("freeze_instr_stable", instruction, 32'hE3A0_0001);
        end
        checkOutput("freeze_req_dropped", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("release_pc12", pc, 32'd12);
        @(negedge clk);
        checkOutput("release_pc16", pc, 32'd16);

        $display("[TB] branch during slow request");
        applyReset(2, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h10 && wait_cnt == 0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("slow_wait_req10", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h103);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr != 32'h10) begin
                found = 1'b1;
                break;
            end
            checkOutput("drop_valid_low", 32'(valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("drop_wait_new_req", 32'(found), 32'd1);
        checkOutput("drop_next_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("drop_wait_valid", 32'(found), 32'd1);
        checkOutput("drop_first_pc", pc, 32'h104);
        checkOutput("drop_first_instr", instruction, mem_word(32'h100));

        $display("[TB] branch with ack and freeze");
        applyReset(0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req && valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("bra_wait_req", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h243);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bra_valid_low", 32'(valid), 32'd0);
        checkOutput("bra_req_high", 32'(imem_req), 32'd1);
        checkOutput("bra_target_addr", imem_addr, 32'h240);

        $display("[TB] reset mid-request");
        applyReset(4, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid && imem_req) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("mid_wait_busy", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("mid_rst_valid", 32'(valid), 32'd0);
        checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
        checkOutput("mid_rst_addr", imem_addr, RST_PC);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("mid_wait_req", 32'(found), 32'd1);
        checkOutput("mid_first_addr", imem_addr, RST_PC);

        $display("[TB] randomized run");
        applyReset(0, 1'b1);
        live_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i == 10) begin
                applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF6);
            end else begin
                applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, $urandom);
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        live_en = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
